series_to_parallel_12: RTL

SERIES_TO_PARALLEL_12 -- requirements
Module: series_to_parallel_12

---
 rtl/series_to_parallel_12_pkg.sv | 18 +
 rtl/series_to_parallel_12_if.sv | 37 +++
 rtl/series_to_parallel_12_index_counter.sv | 87 ++++++++
 rtl/series_to_parallel_12.sv | 73 +++++++
 4 files changed

// File: rtl/series_to_parallel_12_pkg.sv
// Shared vector length, index width and framing states for the 12-element serial-to-parallel path.
package vec12_pkg;

    localparam int VEC_LEN   = 12;
    localparam int IDX_WIDTH = 4;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } vec_state_t;

    function automatic logic [IDX_WIDTH-1:0] next_index(input logic [IDX_WIDTH-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/series_to_parallel_12_if.sv
// Serial element input and assembled 12-wide parallel output bundle.
interface series_to_parallel_12_if #(
    parameter int IN_WIDTH = 11
);

    logic                       inReady;
    logic                       inSeries;
    logic signed [IN_WIDTH-1:0] inData;
    logic                       readyForNewDataSeries;
    logic                       outReady;
    logic                       earlyOutReady;
    logic signed [IN_WIDTH-1:0] P0;
    logic signed [IN_WIDTH-1:0] P1;
    logic signed [IN_WIDTH-1:0] P2;
    logic signed [IN_WIDTH-1:0] P3;
    logic signed [IN_WIDTH-1:0] P4;
    logic signed [IN_WIDTH-1:0] P5;
    logic signed [IN_WIDTH-1:0] P6;
    logic signed [IN_WIDTH-1:0] P7;
    logic signed [IN_WIDTH-1:0] P8;
    logic signed [IN_WIDTH-1:0] P9;
    logic signed [IN_WIDTH-1:0] P10;
    logic signed [IN_WIDTH-1:0] P11;

    modport master (
        output inReady, inSeries, inData,
        input  readyForNewDataSeries, outReady, earlyOutReady,
        input  P0, P1, P2, P3, P4, P5, P6, P7, P8, P9, P10, P11
    );

    modport slave (
        input  inReady, inSeries, inData,
        output readyForNewDataSeries, outReady, earlyOutReady,
        output P0, P1, P2, P3, P4, P5, P6, P7, P8, P9, P10, P11
    );

endinterface

// File: rtl/series_to_parallel_12_index_counter.sv
// Element index counter and IDLE/COLLECT/DONE framing FSM for series_to_parallel_12.
// Optional SERIES_START_ALIGN_EN: vectors only start on inSeries, and inSeries mid-vector restarts framing.
module series_index_counter
    import vec12_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 valid,
    input  logic                 in_series,
    output vec_state_t           state,
    output logic [IDX_WIDTH-1:0] index,
    output logic [IDX_WIDTH-1:0] wr_index,
    output logic                 take,
    output logic                 wrap,
    output logic                 early_full
);

    vec_state_t           state_next;
    logic [IDX_WIDTH-1:0] index_next;
    logic                 start_ok;
    logic                 restart;

`ifdef SERIES_START_ALIGN_EN
    assign start_ok = valid && in_series;
    assign restart  = valid && in_series;
`else
    logic in_series_unused;
    assign in_series_unused = in_series;
    assign start_ok         = valid;
    assign restart          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            index      <= '0;
            early_full <= 1'b0;
        end else if (enable) begin
            state      <= state_next;
            index      <= index_next;
            early_full <= (index_next == LAST_IDX);
        end
    end

    // DONE lasts one cycle but can start the next vector itself, so streams run without a bubble.
    always_comb begin
        state_next = state;
        index_next = index;
        wr_index   = index;
        take       = 1'b0;
        wrap       = 1'b0;
        if (enable) begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        take       = 1'b1;
                        wr_index   = '0;
                        index_next = IDX_WIDTH'(1);
                        state_next = COLLECT;
                    end else begin
                        state_next = IDLE;
                    end
                end
                COLLECT: begin
                    if (restart) begin
                        take       = 1'b1;
                        wr_index   = '0;
                        index_next = IDX_WIDTH'(1);
                    end else if (valid) begin
                        take       = 1'b1;
                        index_next = next_index(index);
                        if (index == LAST_IDX) begin
                            wrap       = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    index_next = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/series_to_parallel_12.sv
// Collects 12 serial signed elements into staging registers and publishes them as P0..P11 with an outReady pulse.
// SERIES_START_ALIGN_EN (handled in series_index_counter) aligns vectors to the inSeries marker.
module series_to_parallel_12
    import vec12_pkg::*;
#(
    parameter int IN_WIDTH = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    series_to_parallel_12_if.slave  bus
);

    vec_state_t                 state;
    logic [IDX_WIDTH-1:0]       index;
    logic [IDX_WIDTH-1:0]       wr_index;
    logic                       take;
    logic                       wrap;
    logic                       early_full;
    logic signed [IN_WIDTH-1:0] stage [VEC_LEN];
    logic signed [IN_WIDTH-1:0] par   [VEC_LEN];

    series_index_counter u_counter (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .valid      (bus.inReady),
        .in_series  (bus.inSeries),
        .state      (state),
        .index      (index),
        .wr_index   (wr_index),
        .take       (take),
        .wrap       (wrap),
        .early_full (early_full)
    );

    // Element 11 bypasses staging so the published vector is complete on the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < VEC_LEN; k++) begin
                stage[k] <= '0;
                par[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < VEC_LEN; k++) begin
                if (take && (wr_index == IDX_WIDTH'(k))) begin
                    stage[k] <= bus.inData;
                end
                if (wrap) begin
                    par[k] <= (wr_index == IDX_WIDTH'(k)) ? bus.inData : stage[k];
                end
            end
        end
    end

    assign bus.outReady              = (state == DONE);
    assign bus.earlyOutReady         = early_full;
    assign bus.readyForNewDataSeries = (index == '0);

    assign bus.P0  = par[0];
    assign bus.P1  = par[1];
    assign bus.P2  = par[2];
    assign bus.P3  = par[3];
    assign bus.P4  = par[4];
    assign bus.P5  = par[5];
    assign bus.P6  = par[6];
    assign bus.P7  = par[7];
    assign bus.P8  = par[8];
    assign bus.P9  = par[9];
    assign bus.P10 = par[10];
    assign bus.P11 = par[11];

endmodule
